// File: rtl/analysis_mode_arbiter_if.sv
// Bundle of the per-engine control/status signals shared between the
// analysis-mode arbiter and its environment. clk/rst_n stay plain ports.
//
// Signalling: there is no valid/ready back-pressure on this bus.
// i_buffer_ready, i_engine_done, o_trigger and o_dropped are single-cycle
// pulses sampled on the rising clk edge. i_engine_busy is a level.
// i_mode_req is asynchronous and is synchronised inside the arbiter.
interface analysis_mode_arbiter_if #(
  parameter int NUM_ENGINES = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int ADDR_WIDTH  = 9
);
  logic [SEL_WIDTH-1:0]              i_mode_req;
  logic                              i_buffer_ready;
  logic [NUM_ENGINES*ADDR_WIDTH-1:0] i_engine_addr;
  logic [NUM_ENGINES-1:0]            i_engine_busy;
  logic [NUM_ENGINES-1:0]            i_engine_done;
  logic [NUM_ENGINES-1:0]            o_trigger;
  logic [ADDR_WIDTH-1:0]             o_buffer_addr;
  logic [SEL_WIDTH-1:0]              o_active_sel;
  logic                              o_switching;
  logic [15:0]                       o_frame_count;
  logic                              o_dropped;
  logic                              o_timeout;
  logic [1:0]                        o_dbg_state;

  // Environment side: drives requests and engine status.
  modport master (
    output i_mode_req, i_buffer_ready, i_engine_addr, i_engine_busy, i_engine_done,
    input  o_trigger, o_buffer_addr, o_active_sel, o_switching, o_frame_count,
           o_dropped, o_timeout, o_dbg_state
  );

  // Arbiter side.
  modport slave (
    input  i_mode_req, i_buffer_ready, i_engine_addr, i_engine_busy, i_engine_done,
    output o_trigger, o_buffer_addr, o_active_sel, o_switching, o_frame_count,
           o_dropped, o_timeout, o_dbg_state
  );
endinterface

// File: rtl/analysis_mode_arbiter.sv
// Analysis-mode arbiter: hands the shared audio buffer to one of
// NUM_ENGINES analysis engines, selected by an asynchronous switch input.
// A mode change waits for the owning engine to go idle (DRAIN), then holds
// off triggers for SETTLE_CYCLES (SETTLE) before the new engine may start.
// Optional feature macro: ARB_WATCHDOG_EN adds a watchdog that bounds the
// time spent in RUN/DRAIN and raises a sticky o_timeout flag.
module analysis_mode_arbiter #(
  parameter int NUM_ENGINES   = 4,
  parameter int SEL_WIDTH     = 2,
  parameter int ADDR_WIDTH    = 9,
  parameter int SETTLE_CYCLES = 16,
  parameter int WDOG_CYCLES   = 1048576
) (
  input  logic                    clk,
  input  logic                    rst_n,
  analysis_mode_arbiter_if.slave  bus
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // Reject parameter sets the arbiter cannot implement.
  if (NUM_ENGINES < 2 || NUM_ENGINES > 8 || (1 << SEL_WIDTH) < NUM_ENGINES ||
      SETTLE_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("analysis_mode_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   sync1_q, sync2_q;
  logic [SEL_WIDTH-1:0]   active_q, active_d;
  logic [15:0]            frame_q, frame_d, frame_inc;
  logic [NUM_ENGINES-1:0] trig_q, trig_d;
  logic                   drop_q, drop_d;
  logic [SCW-1:0]         settle_q, settle_d;
  logic [NUM_ENGINES-1:0] act_onehot;
  logic [ADDR_WIDTH-1:0]  addr_mux;
  logic                   act_done, act_busy, req_diff;
  logic                   wdog_expire;

  // Two-flop synchroniser for the switch input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.i_mode_req;
      sync2_q <= sync1_q;
    end
  end

  // Decode the owning engine: one-hot select, its status bits and its address.
  always_comb begin
    act_onehot = '0;
    addr_mux   = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (active_q == SEL_WIDTH'(k)) begin
        act_onehot[k] = 1'b1;
        addr_mux      = bus.i_engine_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign act_done  = |(bus.i_engine_done & act_onehot);
  assign act_busy  = |(bus.i_engine_busy & act_onehot);
  // Out-of-range requests behave as if they asked for the current engine.
  assign req_diff  = (32'(sync2_q) < NUM_ENGINES) && (sync2_q != active_q);
  assign frame_inc = (frame_q == 16'hFFFF) ? frame_q : frame_q + 16'd1;

`ifdef ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           timeout_q;

  // Expiry fires on the WDOG_CYCLES-th consecutive cycle in RUN/DRAIN.
  assign wdog_expire = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                       (wdog_q == WDW'(WDOG_CYCLES - 1));

  // Watchdog counter restarts on every entry into RUN or DRAIN.
  always_comb begin
    wdog_d = '0;
    if (((state_d == ST_RUN) || (state_d == ST_DRAIN)) && (state_d != state_q))
      wdog_d = '0;
    else if ((state_q == ST_RUN) || (state_q == ST_DRAIN))
      wdog_d = wdog_q + WDW'(1);
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_q | wdog_expire;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign wdog_expire   = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  // Next-state and registered-output logic of the ownership FSM.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    frame_d  = frame_q;
    trig_d   = '0;
    drop_d   = 1'b0;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (req_diff) begin
          // A pending switch wins; a coincident frame is not forwarded.
          state_d = ST_DRAIN;
          drop_d  = bus.i_buffer_ready;
        end else if (bus.i_buffer_ready) begin
          trig_d  = act_onehot;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        drop_d = bus.i_buffer_ready;
        if (act_done) begin
          frame_d = frame_inc;
          state_d = ST_IDLE;
        end else if (wdog_expire) begin
          state_d = ST_IDLE;
        end else if (req_diff) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drop_d = bus.i_buffer_ready;
        if (act_done) frame_d = frame_inc;
        if (!req_diff) begin
          state_d = ST_IDLE;
        end else if ((!act_busy && !act_done) || wdog_expire) begin
          active_d = sync2_q;
          frame_d  = '0;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        drop_d = bus.i_buffer_ready;
        if (settle_q == SCW'(SETTLE_CYCLES - 1)) state_d = ST_IDLE;
        else                                     settle_d = settle_q + SCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      frame_q  <= '0;
      trig_q   <= '0;
      drop_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      frame_q  <= frame_d;
      trig_q   <= trig_d;
      drop_q   <= drop_d;
      settle_q <= settle_d;
    end
  end

  assign bus.o_trigger     = trig_q;
  assign bus.o_dropped     = drop_q;
  assign bus.o_frame_count = frame_q;
  assign bus.o_active_sel  = active_q;
  assign bus.o_buffer_addr = addr_mux;
  assign bus.o_switching   = (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
  assign bus.o_dbg_state   = state_q;

endmodule

// File: tb/tb_analysis_mode_arbiter.sv
// Self-checking bench for analysis_mode_arbiter (NUM_ENGINES=4, SEL_WIDTH=3
// so out-of-range requests can be exercised, SETTLE_CYCLES=16,
// WDOG_CYCLES=1024). Honours ARB_WATCHDOG_EN when defined.
module tb_analysis_mode_arbiter;
  localparam int NE = 4;
  localparam int SW = 3;
  localparam int AW = 9;
  localparam int SC = 16;
  localparam int WD = 1024;

  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_SETTLE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  analysis_mode_arbiter_if #(.NUM_ENGINES(NE), .SEL_WIDTH(SW), .ADDR_WIDTH(AW)) bus ();

  analysis_mode_arbiter #(
    .NUM_ENGINES(NE), .SEL_WIDTH(SW), .ADDR_WIDTH(AW),
    .SETTLE_CYCLES(SC), .WDOG_CYCLES(WD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ownership phase plus time stamps: when the watchdog window began and at
  // which cycle the settle window ends.
  int            m_phase, m_act, m_s1, m_s2;
  longint        cyc, m_entry, m_settle_end;
  logic [15:0]   m_fc;
  logic [NE-1:0] m_trig;
  logic          m_drop, m_to;
  logic [SW-1:0] exp_q[$];

  task automatic model_reset();
    m_phase = P_IDLE; m_act = 0; m_s1 = 0; m_s2 = 0;
    m_fc = '0; m_trig = '0; m_drop = 1'b0; m_to = 1'b0;
    cyc = 0; m_entry = 0; m_settle_end = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit diff, br, a_done, a_busy, wd_exp;
    int nxt;
    br     = bus.i_buffer_ready;
    a_done = bus.i_engine_done[m_act];
    a_busy = bus.i_engine_busy[m_act];
    diff   = (m_s2 < NE) && (m_s2 != m_act);
    wd_exp = 1'b0;
`ifdef ARB_WATCHDOG_EN
    wd_exp = (m_phase == P_RUN || m_phase == P_DRAIN) && (cyc - m_entry == WD - 1);
    if (wd_exp) m_to = 1'b1;
`endif
    m_trig = '0;
    m_drop = 1'b0;
    nxt    = m_phase;
    if (m_phase == P_IDLE) begin
      if (diff) begin
        nxt = P_DRAIN; m_drop = br;
      end else if (br) begin
        m_trig[m_act] = 1'b1; nxt = P_RUN;
        exp_q.push_back(SW'(m_act));
      end
    end else begin
      m_drop = br;
      if (m_phase == P_RUN) begin
        if (a_done) begin
          if (m_fc != 16'hFFFF) m_fc++;
          nxt = P_IDLE;
        end else if (wd_exp) nxt = P_IDLE;
        else if (diff)      nxt = P_DRAIN;
      end else if (m_phase == P_DRAIN) begin
        if (a_done && m_fc != 16'hFFFF) m_fc++;
        if (!diff) nxt = P_IDLE;
        else if ((!a_busy && !a_done) || wd_exp) begin
          m_act = m_s2; m_fc = '0; nxt = P_SETTLE;
          m_settle_end = cyc + SC;
        end
      end else begin
        if (cyc == m_settle_end) nxt = P_IDLE;
      end
    end
    if (nxt != m_phase && (nxt == P_RUN || nxt == P_DRAIN)) m_entry = cyc + 1;
    m_phase = nxt;
    m_s2 = m_s1;
    m_s1 = int'(bus.i_mode_req);
    cyc++;
  endtask

  // Compare process: advance the model on each edge, check every output.
  initial begin
    logic [SW-1:0] got_sel;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
      #2;
      chk("trigger",     bus.o_trigger, m_trig);
      chk("dropped",     bus.o_dropped, m_drop);
      chk("frame_count", bus.o_frame_count, m_fc);
      chk("active_sel",  bus.o_active_sel, SW'(m_act));
      chk("switching",   bus.o_switching, (m_phase == P_DRAIN || m_phase == P_SETTLE));
      chk("timeout",     bus.o_timeout, m_to);
      chk("buffer_addr", bus.o_buffer_addr, bus.i_engine_addr[m_act*AW +: AW]);
      if (bus.o_trigger != '0) begin
        if (exp_q.size() == 0) chk("trigger_unexpected", bus.o_trigger, '0);
        else begin
          got_sel = exp_q.pop_front();
          chk("trigger_target", bus.o_trigger, (NE'(1) << got_sel));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic quiet_inputs();
    bus.i_buffer_ready = 1'b0;
    bus.i_engine_busy  = '0;
    bus.i_engine_done  = '0;
  endtask

  task automatic pulse_br();
    @(negedge clk); bus.i_buffer_ready = 1'b1;
    @(negedge clk); bus.i_buffer_ready = 1'b0;
    #1;
  endtask

  task automatic pulse_done(input int k);
    @(negedge clk); bus.i_engine_done[k] = 1'b1;
    @(negedge clk); bus.i_engine_done[k] = 1'b0;
    #1;
  endtask

  task automatic wait_idle_sel(input int sel);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(bus.o_active_sel == SW'(sel) && !bus.o_switching) && n < 200);
    chk("wait_idle_sel", {bus.o_switching, bus.o_active_sel}, {1'b0, SW'(sel)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NE*AW-1:0] addr_v;
    int cnt;
    bus.i_mode_req    = '0;
    bus.i_engine_addr = '0;
    quiet_inputs();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_trigger", bus.o_trigger, '0);
    chk("rst_active",  bus.o_active_sel, '0);
    chk("rst_frame",   bus.o_frame_count, '0);
    chk("rst_switch",  bus.o_switching, 1'b0);
    chk("rst_state",   bus.o_dbg_state, 2'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Switch request held off by a busy engine, then settle window.
    bus.i_engine_busy[0] = 1'b1;
    pulse_br();
    chk("e0_trigger", bus.o_trigger, 4'b0001);
    bus.i_mode_req = SW'(1);
    repeat (50) @(negedge clk);
    #1;
    chk("drain_hold_sel", bus.o_active_sel, SW'(0));
    chk("drain_hold_sw",  bus.o_switching, 1'b1);
    @(negedge clk); bus.i_engine_busy[0] = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.o_switching && bus.o_active_sel == SW'(1)) cnt++;
    end
    chk("settle_len",   cnt, SC);
    chk("switch_sel",   bus.o_active_sel, SW'(1));
    chk("switch_frame", bus.o_frame_count, 16'd0);

    // Dropped frames in RUN and in SETTLE.
    pulse_br();
    chk("e1_trigger", bus.o_trigger, 4'b0010);
    pulse_br();
    chk("run_drop",      bus.o_dropped, 1'b1);
    chk("run_drop_trig", bus.o_trigger, 4'b0000);
    pulse_done(1);
    chk("e1_frame", bus.o_frame_count, 16'd1);
    bus.i_mode_req = SW'(2);
    cnt = 0;
    do begin @(negedge clk); #1; cnt++; end while (bus.o_active_sel != SW'(2) && cnt < 50);
    pulse_br();
    chk("settle_drop",      bus.o_dropped, 1'b1);
    chk("settle_drop_trig", bus.o_trigger, 4'b0000);
    wait_idle_sel(2);

    // Address mux, trigger and frame count on engine 2.
    addr_v = '0;
    addr_v[2*AW +: AW] = 9'h1A5;
    addr_v[0 +: AW]    = 9'h033;
    bus.i_engine_addr  = addr_v;
    #1;
    chk("addr_e2", bus.o_buffer_addr, 9'h1A5);
    pulse_br();
    chk("e2_trigger", bus.o_trigger, 4'b0100);
    @(negedge clk); #1;
    chk("e2_trig_once", bus.o_trigger, 4'b0000);
    pulse_done(2);
    chk("e2_frame", bus.o_frame_count, 16'd1);

    // Out-of-range request is ignored.
    bus.i_mode_req = SW'(5);
    repeat (10) @(negedge clk);
    #1;
    chk("oor_sel", bus.o_active_sel, SW'(2));
    chk("oor_sw",  bus.o_switching, 1'b0);

    // Asynchronous reset in the middle of a frame on engine 3.
    bus.i_mode_req = SW'(3);
    wait_idle_sel(3);
    pulse_br();
    pulse_done(3);
    pulse_br();
    chk("e3_trigger", bus.o_trigger, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trig",   bus.o_trigger, '0);
    chk("mid_rst_sel",    bus.o_active_sel, '0);
    chk("mid_rst_frame",  bus.o_frame_count, '0);
    chk("mid_rst_switch", bus.o_switching, 1'b0);
    bus.i_mode_req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      chk("post_rst_quiet", {bus.o_trigger, bus.o_dropped}, '0);
    end

    // Watchdog: trigger with no completion.
    pulse_br();
    chk("wd_trigger", bus.o_trigger, 4'b0001);
    repeat (1030) @(negedge clk);
    #1;
`ifdef ARB_WATCHDOG_EN
    chk("wd_timeout", bus.o_timeout, 1'b1);
    chk("wd_idle",    bus.o_dbg_state, 2'd0);
    pulse_br();
    chk("wd_retrigger", bus.o_trigger, 4'b0001);
`else
    chk("wd_timeout", bus.o_timeout, 1'b0);
    pulse_br();
    chk("wd_still_run", bus.o_dropped, 1'b1);
    pulse_done(0);
`endif

    // Randomised traffic against the model.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.i_mode_req = SW'($urandom_range(0, 7));
      bus.i_buffer_ready = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < NE; k++) begin
        if ($urandom_range(0, 7) == 0) bus.i_engine_busy[k] = ~bus.i_engine_busy[k];
        bus.i_engine_done[k] = ($urandom_range(0, 11) == 0);
      end
      addr_v = {$urandom, $urandom};
      bus.i_engine_addr = addr_v;
    end
    @(negedge clk);
    quiet_inputs();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/analysis_mode_arbiter.md
ANALYSIS_MODE_ARBITER -- requirements
Module: analysis_mode_arbiter

Interface
REQ-001 Parameter NUM_ENGINES, default 4, number of analysis engines sharing the audio buffer (2..8).
REQ-002 Parameter SEL_WIDTH, default 2, width of engine index; SHALL satisfy 2**SEL_WIDTH >= NUM_ENGINES.
REQ-003 Parameter ADDR_WIDTH, default 9, audio buffer read address width.
REQ-004 Parameter SETTLE_CYCLES, default 16, quiet cycles after a mode switch (>= 1).
REQ-005 Parameter WDOG_CYCLES, default 1048576, watchdog limit in clk cycles.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 i_mode_req  input  SEL_WIDTH  requested engine index from switches, asynchronous to clk.
REQ-009 i_buffer_ready  input  1  single-cycle pulse, audio frame available.
REQ-010 i_engine_addr  input  NUM_ENGINES*ADDR_WIDTH  packed per-engine buffer read addresses, engine k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 i_engine_busy  input  NUM_ENGINES  per-engine busy level.
REQ-012 i_engine_done  input  NUM_ENGINES  per-engine single-cycle completion pulse.
REQ-013 o_trigger  output  NUM_ENGINES  one-hot single-cycle start pulse.
REQ-014 o_buffer_addr  output  ADDR_WIDTH  address forwarded to the audio buffer.
REQ-015 o_active_sel  output  SEL_WIDTH  currently owning engine.
REQ-016 o_switching  output  1  high in DRAIN and SETTLE.
REQ-017 o_frame_count  output  16  frames completed by active engine since last switch.
REQ-018 o_dropped  output  1  single-cycle pulse, buffer_ready not forwarded.
REQ-019 o_timeout  output  1  sticky watchdog flag.

Function
REQ-020 i_mode_req SHALL pass a 2-flop synchroniser; "sync_req" denotes its output; values >= NUM_ENGINES SHALL be ignored (treated equal to o_active_sel).
REQ-021 o_buffer_addr SHALL be a combinational mux of i_engine_addr indexed by o_active_sel (zero added latency).
REQ-022 FSM states IDLE, RUN, DRAIN, SETTLE; o_trigger, o_dropped, o_frame_count, o_active_sel registered.
REQ-023 IDLE: sync_req != o_active_sel -> DRAIN (takes priority); else i_buffer_ready -> o_trigger[o_active_sel]=1 next cycle, -> RUN.
REQ-024 RUN: i_engine_done[o_active_sel] -> o_frame_count+1 (saturate at 16'hFFFF), -> IDLE; else sync_req != o_active_sel -> DRAIN; done of non-active engines ignored.
REQ-025 DRAIN: i_engine_busy[o_active_sel]==0 and i_engine_done[o_active_sel]==0 -> o_active_sel=sync_req, o_frame_count=0, -> SETTLE; a done pulse in DRAIN SHALL still increment o_frame_count before the switch.
REQ-026 DRAIN: if sync_req returns to o_active_sel before busy drops -> IDLE, no switch, count kept.
REQ-027 SETTLE: no triggers for exactly SETTLE_CYCLES cycles, then -> IDLE; a further sync_req change during SETTLE is honoured only after return to IDLE.
REQ-028 i_buffer_ready in RUN, DRAIN or SETTLE, or coincident with done in RUN, SHALL produce o_dropped=1 for one cycle and no trigger.
REQ-029 At most one o_trigger bit SHALL be high in any cycle, never two consecutive cycles.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, o_active_sel=0, synchroniser flops 0, o_trigger=0, o_dropped=0, o_frame_count=0, o_timeout=0, watchdog counter 0; o_switching=0.
REQ-031 Reset mid-RUN SHALL abandon the frame; no trigger or dropped pulse on release.

Configuration
REQ-032 Macro ARB_WATCHDOG_EN defined: counter clears on entry to RUN/DRAIN, increments each cycle there; on reaching WDOG_CYCLES, o_timeout set (sticky until reset), RUN -> IDLE without count increment, DRAIN -> switch as in REQ-025.
REQ-033 ARB_WATCHDOG_EN undefined: no counter synthesised, o_timeout constant 0, RUN/DRAIN wait indefinitely.

Verification (NUM_ENGINES=4, SETTLE_CYCLES=16, WDOG_CYCLES=1024)
REQ-034 mode_req=2, addr engine2=9'h1A5, buffer_ready pulse -> o_buffer_addr=9'h1A5, o_trigger=4'b0100 one cycle, done[2] -> o_frame_count=1.
REQ-035 In RUN on engine 0 change mode_req to 1, busy[0] held 50 cycles -> o_active_sel stays 0 until busy drops, then 1, o_switching high through 16 SETTLE cycles, o_frame_count=0.
REQ-036 buffer_ready during RUN and during SETTLE -> o_dropped pulses twice, o_trigger stays 0.
REQ-037 mode_req=3'b... value 5 with SEL_WIDTH=3, NUM_ENGINES=4 -> no switch, o_active_sel unchanged.
REQ-038 ARB_WATCHDOG_EN, trigger then no done -> after 1024 cycles o_timeout=1, state IDLE, next buffer_ready triggers; without macro o_timeout=0 forever.
REQ-039 rst_n low mid-RUN on engine 3 -> o_active_sel=0, outputs zero immediately, no pulses after release.
